// File: rtl/l2_pkg.sv
// Shared state type and default geometry for the L2 line-to-burst adaptor.
package l2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } l2_state_e;

    localparam int L2_LINE_W   = 256;
    localparam int L2_BEAT_W   = 64;
    localparam int L2_OFFSET_W = 5;
    localparam int L2_BEATS    = L2_LINE_W / L2_BEAT_W;

endpackage

// File: rtl/l2_timeout_ctr.sv
// Watchdog for the adaptor: counts consecutive busy cycles without a beat
// acknowledge and raises a one-cycle trip plus a sticky error flag.
module l2_timeout_ctr #(
    parameter int limit = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ack,
    output logic trip,
    output logic err_o
);
    localparam int cnt_w = $clog2(limit + 1);

    logic [cnt_w-1:0] cnt_reg;
    logic             err_reg;

    // Trip on the limit-th silent busy cycle so the FSM lands in DONE next.
    assign trip  = busy && !ack && (cnt_reg == cnt_w'(limit - 1));
    assign err_o = err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (!busy || ack || trip) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + cnt_w'(1);
            end
            if (trip) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_cacheline_adaptor.sv
// Converts L2 line reads/writes into fixed-length beat bursts on the memory port.
// Optional watchdog (err_o port) is built when L2_ADAPTOR_TIMEOUT_EN is defined.
module l2_cacheline_adaptor
    import l2_pkg::*;
#(
    parameter int s_line   = L2_LINE_W,
    parameter int s_burst  = L2_BEAT_W,
    parameter int s_offset = L2_OFFSET_W
`ifdef L2_ADAPTOR_TIMEOUT_EN
    ,
    parameter int timeout_cycles = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    output logic               resp_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [s_burst-1:0] burst_o,
    input  logic [s_burst-1:0] burst_i,
    input  logic               resp_i
`ifdef L2_ADAPTOR_TIMEOUT_EN
    ,
    output logic               err_o
`endif
);
    localparam int beats = s_line / s_burst;
    localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

    l2_state_e          state_reg, state_next;
    logic [cnt_w-1:0]   count_reg, count_next;
    logic [31:0]        addr_reg;
    logic [s_line-1:0]  wline_reg, shadow_reg, line_reg, shadow_merged;
    logic [s_burst-1:0] wslot [beats];
    logic               last_beat, busy, trip;

    assign last_beat  = (count_reg == cnt_w'(beats - 1));
    assign count_next = last_beat ? '0 : count_reg + cnt_w'(1);
    assign busy       = (state_reg == READ) || (state_reg == WRITE);

    // Slot view of the write line and the shadow line with the incoming beat merged in.
    genvar gi;
    generate
        for (gi = 0; gi < beats; gi++) begin : g_slot
            assign wslot[gi] = wline_reg[gi*s_burst +: s_burst];
            assign shadow_merged[gi*s_burst +: s_burst] =
                (count_reg == cnt_w'(gi)) ? burst_i : shadow_reg[gi*s_burst +: s_burst];
        end
    endgenerate

    assign burst_o   = wslot[count_reg];
    assign address_o = addr_reg;
    assign line_o    = line_reg;

`ifdef L2_ADAPTOR_TIMEOUT_EN
    l2_timeout_ctr #(
        .limit (timeout_cycles)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .busy  (busy),
        .ack   (resp_i),
        .trip  (trip),
        .err_o (err_o)
    );
`else
    assign trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            addr_reg   <= '0;
            wline_reg  <= '0;
            shadow_reg <= '0;
            line_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && (read_i || write_i)) begin
                addr_reg  <= address_i & addr_mask;
                count_reg <= '0;
                if (write_i) begin
                    wline_reg <= line_i;
                end
            end
            if (busy && resp_i) begin
                count_reg <= count_next;
                // line_o only changes once the whole line has arrived.
                if (state_reg == READ) begin
                    shadow_reg <= shadow_merged;
                    if (last_beat) begin
                        line_reg <= shadow_merged;
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        read_o     = 1'b0;
        write_o    = 1'b0;
        resp_o     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (write_i) begin
                    state_next = WRITE;
                end else if (read_i) begin
                    state_next = READ;
                end
            end
            READ: begin
                read_o = 1'b1;
                if (trip || (resp_i && last_beat)) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                write_o = 1'b1;
                if (trip || (resp_i && last_beat)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                resp_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Self-checking bench for l2_cacheline_adaptor: directed and randomised line
// reads/writes against a transaction-level expectation of the memory port.
module tb_l2_cacheline_adaptor;
    import l2_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [31:0]    address_i = '0;
    logic           read_i = 1'b0;
    logic           write_i = 1'b0;
    logic [255:0]   line_i = '0;
    logic [255:0]   line_o;
    logic           resp_o;
    logic [31:0]    address_o;
    logic           read_o;
    logic           write_o;
    logic [63:0]    burst_o;
    logic [63:0]    burst_i = '0;
    logic           resp_i = 1'b0;
`ifdef L2_ADAPTOR_TIMEOUT_EN
    logic           err_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [255:0] line_model = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    l2_cacheline_adaptor #(
        .s_line   (256),
        .s_burst  (64),
        .s_offset (5)
`ifdef L2_ADAPTOR_TIMEOUT_EN
        ,
        .timeout_cycles (16)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
`ifdef L2_ADAPTOR_TIMEOUT_EN
        ,
        .err_o     (err_o)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] slot(input logic [255:0] line, input int k);
        logic [255:0] sh;
        sh = line >> (64 * k);
        return sh[63:0];
    endfunction

    // One line read; beats are the 64-bit slices of 'line', low slice first.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input int min_gap, input int max_gap);
        int req_cyc, gaps, g;
        gaps = 0;
        read_i = 1'b1;
        address_i = addr;
        req_cyc = cyc;
        @(negedge clk);
        chk("rd_req", read_o, 1'b1);
        chk("rd_addr", address_o, addr & 32'hFFFF_FFE0);
        for (int k = 0; k < 4; k++) begin
            g = $urandom_range(max_gap, min_gap);
            gaps += g;
            repeat (g) begin
                resp_i = 1'b0;
                burst_i = {$urandom, $urandom};
                @(negedge clk);
                chk("rd_gap", {address_o, read_o, write_o, resp_o}, {addr & 32'hFFFF_FFE0, 3'b100});
            end
            resp_i = 1'b1;
            burst_i = slot(line, k);
            @(negedge clk);
            resp_i = 1'b0;
            burst_i = {$urandom, $urandom};
            if (k < 3) chk("rd_partial", line_o, line_model);
        end
        chk("rd_resp", {resp_o, read_o}, 2'b10);
        chk("rd_latency", cyc - req_cyc, 5 + gaps);
        line_model = line;
        chk("rd_line", line_o, line_model);
        read_i = 1'b0;
        @(negedge clk);
        chk("rd_resp_once", {resp_o, read_o}, 2'b00);
        chk("rd_line_hold", line_o, line_model);
    endtask

    // One line write; optionally with read_i also high, or a stray read pulse mid-burst.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int min_gap, input int max_gap,
                            input bit both_high, input bit pulse_read);
        int g;
        write_i = 1'b1;
        read_i = both_high;
        address_i = addr;
        line_i = line;
        @(negedge clk);
        line_i = {8{$urandom}};
        chk("wr_req", {write_o, read_o}, 2'b10);
        chk("wr_addr", address_o, addr & 32'hFFFF_FFE0);
        for (int k = 0; k < 4; k++) begin
            chk("wr_beat", burst_o, slot(line, k));
            g = $urandom_range(max_gap, min_gap);
            for (int j = 0; j < g; j++) begin
                resp_i = 1'b0;
                read_i = both_high || (pulse_read && k == 1 && j == 0);
                @(negedge clk);
                read_i = both_high;
                chk("wr_hold", {burst_o, write_o, read_o, resp_o}, {slot(line, k), 3'b100});
            end
            resp_i = 1'b1;
            @(negedge clk);
            resp_i = 1'b0;
        end
        chk("wr_resp", {resp_o, write_o, read_o}, 3'b100);
        chk("wr_line_o_kept", line_o, line_model);
        write_i = 1'b0;
        read_i = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("wr_quiet", {resp_o, write_o, read_o}, 3'b000);
        end
    endtask

    initial begin
        logic [255:0] ln;
        logic [31:0]  ad;

        #1;
        chk("rst_outputs", {read_o, write_o, resp_o}, 3'b000);
        chk("rst_addr", address_o, 32'h0);
        chk("rst_burst", burst_o, 64'h0);
        chk("rst_line", line_o, 256'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_quiet", {read_o, write_o, resp_o}, 3'b000);

        // Directed read, back-to-back beats.
        ln = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_read(32'h0000_1234, ln, 0, 0);
        chk("rd_addr_exact", address_o, 32'h0000_1220);

        // Directed write, ack every third cycle.
        ln = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        do_write(32'h0000_4000, ln, 2, 2, 1'b0, 1'b0);

        // Simultaneous read/write requests: write wins.
        do_write(32'h8000_007F, {8{$urandom}}, 0, 1, 1'b1, 1'b0);

        // Stray read pulse during a write is ignored.
        do_write(32'h1234_5678, {8{$urandom}}, 1, 2, 1'b0, 1'b1);

        // Reset two beats into a read.
        read_i = 1'b1;
        address_i = 32'hCAFE_F00D;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            resp_i = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_outputs", {read_o, write_o, resp_o}, 3'b000);
        chk("abort_addr", address_o, 32'h0);
        chk("abort_burst", burst_o, 64'h0);
        chk("abort_line", line_o, 256'h0);
        line_model = '0;
        @(negedge clk);
        chk("abort_no_resp", resp_o, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        do_read(32'hCAFE_F00D, {8{$urandom}}, 0, 2);

        // Randomised mix.
        for (int t = 0; t < 12; t++) begin
            ad = $urandom;
            ln = {8{$urandom}};
            if ($urandom_range(1, 0) == 1) do_read(ad, ln, 0, 3);
            else do_write(ad, ln, 0, 3, 1'b0, 1'b0);
        end

`ifdef L2_ADAPTOR_TIMEOUT_EN
        chk("wd_err_clear", err_o, 1'b0);
        read_i = 1'b1;
        address_i = 32'h0000_0100;
        @(negedge clk);
        for (int j = 1; j < 16; j++) begin
            @(negedge clk);
            chk("wd_wait", {resp_o, err_o}, 2'b00);
        end
        @(negedge clk);
        read_i = 1'b0;
        chk("wd_trip", {resp_o, err_o, read_o}, 3'b110);
        chk("wd_line_kept", line_o, line_model);
        @(negedge clk);
        chk("wd_sticky", {resp_o, err_o}, 2'b01);
        do_read(32'h0000_0200, {8{$urandom}}, 0, 1);
        chk("wd_sticky2", err_o, 1'b1);
        rst = 1'b0;
        #1;
        chk("wd_reset", err_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
